// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the word-to-halfword SRAM controller.
package sram_controller_pkg;

    localparam int unsigned SRAM_DW           = 16;
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/sram_controller_if.sv
// Requester-side load/store bus between the MEM stage and the SRAM controller.
interface sram_controller_if;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, writeData,
        input  readData, ready
    );

    modport slave (
        input  wr_en, rd_en, address, writeData,
        output readData, ready
    );

endinterface

// File: rtl/sram_controller.sv
// Serves 32-bit load/store requests as two 16-bit accesses to an external SRAM,
// followed by a configurable settle wait; ready drops while an access is pending.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    sram_controller_if.slave    bus,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [SRAM_DW-1:0]  sram_dq_out,
    input  logic [SRAM_DW-1:0]  sram_dq_in,
    output logic                sram_dq_oe,
    output logic                sram_we_n
);

    localparam int unsigned WORD_W = SRAM_AW - 1;
    localparam int unsigned CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t             state_q, state_d;
    logic               is_write_q, is_write_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [31:0]        data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        read_data_q, read_data_d;
    logic [SRAM_AW-1:0] sram_addr_d;
    logic [SRAM_DW-1:0] sram_dq_out_d;
    logic               sram_dq_oe_d;
    logic               sram_we_n_d;

    // Below-base addresses wrap through the unsigned subtract.
    logic [31:0]        offset;
    logic [WORD_W-1:0]  word_new;
    logic               unused_offset_bits;

    assign offset             = bus.address - BASE_ADDR;
    assign word_new           = offset[SRAM_AW:2];
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    assign bus.readData = read_data_q;
    assign bus.ready    = ((state_q == ST_IDLE) && !bus.rd_en && !bus.wr_en)
                        || (state_q == ST_DONE);

    // Next state plus next values of the registered SRAM pins.
    always_comb begin
        state_d       = state_q;
        is_write_d    = is_write_q;
        word_d        = word_q;
        data_d        = data_q;
        cnt_d         = cnt_q;
        read_data_d   = read_data_q;
        sram_addr_d   = sram_addr;
        sram_dq_out_d = sram_dq_out;
        sram_dq_oe_d  = 1'b0;
        sram_we_n_d   = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.rd_en || bus.wr_en) begin
                    is_write_d   = bus.wr_en;
                    word_d       = word_new;
                    data_d       = bus.writeData;
                    state_d      = ST_LO;
                    sram_addr_d  = {word_new, 1'b0};
                    sram_dq_oe_d = bus.wr_en;
                    sram_we_n_d  = !bus.wr_en;
                    if (bus.wr_en) sram_dq_out_d = bus.writeData[15:0];
                end
            end
            ST_LO: begin
                state_d      = ST_HI;
                sram_addr_d  = {word_q, 1'b1};
                sram_dq_oe_d = is_write_q;
                sram_we_n_d  = !is_write_q;
                if (is_write_q) sram_dq_out_d = data_q[31:16];
                else            read_data_d[15:0] = sram_dq_in;
            end
            ST_HI: begin
                state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
                cnt_d   = '0;
                if (!is_write_q) read_data_d[31:16] = sram_dq_in;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            is_write_q  <= 1'b0;
            word_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            read_data_q <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            word_q      <= word_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            sram_addr   <= sram_addr_d;
            sram_dq_out <= sram_dq_out_d;
            sram_dq_oe  <= sram_dq_oe_d;
            sram_we_n   <= sram_we_n_d;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: default-wait and zero-wait instances, each with a small SRAM model.
module tb_sram_controller;
    import sram_controller_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_controller_if bus0 ();
    sram_controller_if bus1 ();

    logic [17:0] sram_addr0, sram_addr1;
    logic [15:0] dq_out0, dq_out1, dq_in0, dq_in1;
    logic        oe0, oe1, we_n0, we_n1;

    sram_controller #(.WAIT_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .sram_addr(sram_addr0), .sram_dq_out(dq_out0), .sram_dq_in(dq_in0),
        .sram_dq_oe(oe0), .sram_we_n(we_n0)
    );

    sram_controller #(.WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .sram_addr(sram_addr1), .sram_dq_out(dq_out1), .sram_dq_in(dq_in1),
        .sram_dq_oe(oe1), .sram_we_n(we_n1)
    );

    // Asynchronous-read SRAMs; a write strobe is inhibited while the board is in reset.
    logic [15:0] mem0 [0:63];
    logic [15:0] mem1 [0:63];
    assign dq_in0 = mem0[sram_addr0[5:0]];
    assign dq_in1 = mem1[sram_addr1[5:0]];
    always @(posedge clk) if (!we_n0 && !rst) mem0[sram_addr0[5:0]] <= dq_out0;
    always @(posedge clk) if (!we_n1 && !rst) mem1[sram_addr1[5:0]] <= dq_out1;

    int checks;
    int failures;
    logic [31:0] exp_rd_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic wr, input logic rd,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.wr_en = wr; bus0.rd_en = rd; bus0.address = a; bus0.writeData = d;
        end else begin
            bus1.wr_en = wr; bus1.rd_en = rd; bus1.address = a; bus1.writeData = d;
        end
    endtask

    function automatic logic cur_ready(input int sel);
        return (sel == 0) ? bus0.ready : bus1.ready;
    endfunction

    function automatic logic cur_we_n(input int sel);
        return (sel == 0) ? we_n0 : we_n1;
    endfunction

    function automatic logic [31:0] cur_rdata(input int sel);
        return (sel == 0) ? bus0.readData : bus1.readData;
    endfunction

    // Present one request at the current cycle (cycle 0), follow it to the ready pulse,
    // then drop it right after the completing edge so a following call starts the next cycle.
    task automatic access(input int sel, input logic wr, input logic rd,
                          input logic [31:0] a, input logic [31:0] d,
                          input int exp_lat, input logic [31:0] exp_rd, input string tag);
        int          n;
        logic        got;
        logic [31:0] we_mask;
        logic [31:0] exp_q;
        exp_rd_q.push_back(exp_rd);
        drive(sel, wr, rd, a, d);
        n       = 0;
        got     = 1'b0;
        we_mask = '0;
        while (!got && n < 30) begin
            @(negedge clk);
            if (!cur_we_n(sel)) we_mask[n] = 1'b1;
            if (cur_ready(sel)) got = 1'b1;
            else                n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_we_cycles"}, we_mask, wr ? 32'h0000_0006 : 32'h0);
        exp_q = exp_rd_q.pop_front();
        check({tag, "_readData"}, cur_rdata(sel), exp_q);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", 32'(bus0.ready), 32'd1);
            check("idle_we_n", 32'(we_n0), 32'd1);
            check("idle_oe", 32'(oe0), 32'd0);
            check("idle_readData", bus0.readData, 32'h0);
        end
        @(posedge clk);
        #1;

        // Write then read back the base word
        access(0, 1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 7, 32'h0, "wr1024");
        check("mem0_0", 32'(mem0[0]), 32'h0000_BEEF);
        check("mem0_1", 32'(mem0[1]), 32'h0000_DEAD);
        access(0, 1'b0, 1'b1, 32'd1024, 32'h0, 7, 32'hDEAD_BEEF, "rd1024");

        // Back-to-back: the read is presented in the IDLE cycle right after DONE
        access(0, 1'b1, 1'b0, 32'd1028, 32'h1234_5678, 7, 32'hDEAD_BEEF, "b2b_wr");
        access(0, 1'b0, 1'b1, 32'd1028, 32'h0, 7, 32'h1234_5678, "b2b_rd");
        check("mem0_2", 32'(mem0[2]), 32'h0000_5678);
        check("mem0_3", 32'(mem0[3]), 32'h0000_1234);

        // Simultaneous rd/wr resolves as a write and leaves readData alone
        access(0, 1'b1, 1'b1, 32'd1032, 32'hA5A5_A5A5, 7, 32'h1234_5678, "rdwr");
        check("mem0_4", 32'(mem0[4]), 32'h0000_A5A5);
        check("mem0_5", 32'(mem0[5]), 32'h0000_A5A5);

        // Known contents at 1036 so a skipped high-half write is visible
        access(0, 1'b1, 1'b0, 32'd1036, 32'h1111_2222, 7, 32'h1234_5678, "pre1036");

        // Reset during the high-half access of a write
        drive(0, 1'b1, 1'b0, 32'd1036, 32'hCAFE_F00D);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_we_n", 32'(we_n0), 32'd1);
        check("rst_oe", 32'(oe0), 32'd0);
        check("rst_ready", 32'(bus0.ready), 32'd1);
        check("rst_readData", bus0.readData, 32'h0);
        check("rst_mem0_6", 32'(mem0[6]), 32'h0000_F00D);
        check("rst_mem0_7", 32'(mem0[7]), 32'h0000_1111);
        @(posedge clk);
        #1;

        // Zero-wait instance
        access(1, 1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 3, 32'h0, "w0_wr1024");
        check("mem1_0", 32'(mem1[0]), 32'h0000_BEEF);
        check("mem1_1", 32'(mem1[1]), 32'h0000_DEAD);
        access(1, 1'b0, 1'b1, 32'd1024, 32'h0, 3, 32'hDEAD_BEEF, "w0_rd1024");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
